// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter feeding packets from NREQ requesters to one UART transmitter.
// Optional stall eviction is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arb #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_de,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state;
    logic [3:0]  r_grant;
    logic [3:0]  w_grant;
    logic [1:0]  r_owner;
    logic [1:0]  w_owner;
    logic [1:0]  r_last;
    logic [1:0]  w_last;
    logic        r_tx_de;
    logic        w_tx_de;
    logic [7:0]  r_tx_data;
    logic [7:0]  w_tx_data;
    logic        r_lflag;
    logic        w_lflag;

    logic        w_any;
    logic [1:0]  w_win;
    logic [1:0]  w_cand;
    logic        w_sel_valid;
    logic [7:0]  w_sel_data;
    logic        w_sel_last;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] r_cnt;
    logic          r_timeout;
    logic          w_timeout;
    logic          w_cnt_clr;
    logic          w_cnt_inc;
`endif

    assign w_any       = |req_valid;
    assign w_sel_valid = req_valid[r_owner];
    assign w_sel_data  = req_data[{r_owner, 3'b000} +: 8];
    assign w_sel_last  = req_last[r_owner];

    // Round-robin search starting just after the previous owner; lowest offset wins.
    always_comb begin
        w_win  = r_last;
        w_cand = r_last;
        for (int k = 4; k >= 1; k--) begin
            w_cand = r_last + 2'(k);
            if (req_valid[w_cand]) begin
                w_win = w_cand;
            end
        end
    end

    // State and datapath registers; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_owner   <= 2'd0;
            r_last    <= 2'd3;
            r_tx_de   <= 1'b0;
            r_tx_data <= 8'h00;
            r_lflag   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_grant   <= w_grant;
            r_owner   <= w_owner;
            r_last    <= w_last;
            r_tx_de   <= w_tx_de;
            r_tx_data <= w_tx_data;
            r_lflag   <= w_lflag;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Stall counter and eviction pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout;
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
`endif

    // Next-state logic: grant in IDLE, take a byte in SEND, await tx_done in WAIT.
    always_comb begin
        w_state   = r_state;
        w_grant   = r_grant;
        w_owner   = r_owner;
        w_last    = r_last;
        w_tx_de   = 1'b0;
        w_tx_data = r_tx_data;
        w_lflag   = r_lflag;
`ifdef UART_ARB_TIMEOUT_EN
        w_timeout = 1'b0;
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state = SEND;
                    w_grant = 4'b0001 << w_win;
                    w_owner = w_win;
`ifdef UART_ARB_TIMEOUT_EN
                    w_cnt_clr = 1'b1;
`endif
                end
            end
            SEND: begin
                if (w_sel_valid) begin
                    w_state   = WAIT;
                    w_tx_de   = 1'b1;
                    w_tx_data = w_sel_data;
                    w_lflag   = w_sel_last;
`ifdef UART_ARB_TIMEOUT_EN
                    w_cnt_clr = 1'b1;
`endif
                end else begin
`ifdef UART_ARB_TIMEOUT_EN
                    if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        w_state   = IDLE;
                        w_grant   = '0;
                        w_last    = r_owner;
                        w_timeout = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
`endif
                end
            end
            WAIT: begin
                if (tx_done) begin
                    if (r_lflag) begin
                        w_state = IDLE;
                        w_grant = '0;
                        w_last  = r_owner;
                    end else begin
                        w_state = SEND;
                    end
                end
            end
            default: begin
                w_state = IDLE;
                w_grant = '0;
            end
        endcase
    end

    assign req_ready = (r_state == SEND) ? r_grant : '0;
    assign tx_de     = r_tx_de;
    assign tx_data   = r_tx_data;
    assign grant     = r_grant;
    assign busy      = (r_state != IDLE);

`ifdef UART_ARB_TIMEOUT_EN
    assign timeout = r_timeout;
`else
    logic [31:0] w_unused_tmo;
    assign w_unused_tmo = TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

endmodule
